// File: rtl/cmd_frame_parser.sv
// cmd_frame_parser: framed command receiver fed by a UART RX byte stream.
//
// Hunts for HDR_LEN consecutive HDR_BYTE values, then reads a command byte and
// a length byte, streams LEN payload bytes, and finally fires a one-hot start
// pulse on the selected command channel. The parser then stays locked until
// that channel reports done. An inter-byte timeout abandons partial frames.
//
// Ports:
//   clk, reset           clock, asynchronous active-high reset
//   rx_valid, rx_data    received byte (level, UART RX interrupt)
//   rx_clear             one-cycle acknowledge of an accepted byte
//   payload_valid/data/idx  payload byte stream, idx 0-based
//   frame_cmd, frame_len latched command code and length of the current frame
//   cmd_start            one-hot start pulse (bit c-1 for command c)
//   cmd_active           one-hot, high while a command is dispatched or locked
//   cmd_done             per-channel unlock, only the active bit is honoured
//   idle                 hunting with no header bytes seen
//   err_valid, err_code  error pulse; code 1=bad cmd, 2=bad len, 3=timeout
module cmd_frame_parser #(
    parameter int unsigned       DATA_W   = 8,
    parameter int unsigned       NUM_CMDS = 4,
    parameter int unsigned       HDR_LEN  = 2,
    parameter logic [DATA_W-1:0] HDR_BYTE = 8'hFE,
    parameter int unsigned       MAX_LEN  = 64,
    parameter int unsigned       TO_W     = 16,
    parameter int unsigned       TIMEOUT  = 50000,
    localparam int unsigned      CMD_W    = $clog2(NUM_CMDS + 1)
) (
    input  logic                clk,
    input  logic                reset,
    input  logic                rx_valid,
    input  logic [DATA_W-1:0]   rx_data,
    output logic                rx_clear,
    output logic                payload_valid,
    output logic [DATA_W-1:0]   payload_data,
    output logic [DATA_W-1:0]   payload_idx,
    output logic [CMD_W-1:0]    frame_cmd,
    output logic [DATA_W-1:0]   frame_len,
    output logic [NUM_CMDS-1:0] cmd_start,
    output logic [NUM_CMDS-1:0] cmd_active,
    input  logic [NUM_CMDS-1:0] cmd_done,
    output logic                idle,
    output logic                err_valid,
    output logic [1:0]          err_code
);

    localparam logic [1:0] ErrCmd     = 2'd1;
    localparam logic [1:0] ErrLen     = 2'd2;
    localparam logic [1:0] ErrTimeout = 2'd3;

    typedef enum logic [2:0] {
        StHunt, StCmd, StLen, StPayload, StDispatch, StLocked
    } state_e;

    state_e              state_q, state_d;
    logic [3:0]          hdr_cnt_q, hdr_cnt_d;
    logic [TO_W-1:0]     to_cnt_q, to_cnt_d;
    logic [DATA_W-1:0]   pay_cnt_q, pay_cnt_d;
    logic [CMD_W-1:0]    frame_cmd_q, frame_cmd_d;
    logic [DATA_W-1:0]   frame_len_q, frame_len_d;
    logic                rx_clear_q, rx_clear_d;
    logic                payload_valid_q, payload_valid_d;
    logic [DATA_W-1:0]   payload_data_q, payload_data_d;
    logic [DATA_W-1:0]   payload_idx_q, payload_idx_d;
    logic                err_valid_q, err_valid_d;
    logic [1:0]          err_code_q, err_code_d;

    logic [NUM_CMDS-1:0] cmd_sel;
    logic                accept, cmd_ok, done_hit, to_run, to_expire;

    always_comb begin
        for (int c = 0; c < NUM_CMDS; c++) begin
            cmd_sel[c] = (frame_cmd_q == CMD_W'(c + 1));
        end
    end

    // DISPATCH is the only state that leaves a pending byte untouched.
    assign accept   = rx_valid && (state_q != StDispatch);
    assign cmd_ok   = (rx_data != '0) && (rx_data <= DATA_W'(NUM_CMDS));
    assign done_hit = |(cmd_done & cmd_sel);
    assign to_run   = (state_q == StCmd) || (state_q == StLen) || (state_q == StPayload) ||
                      ((state_q == StHunt) && (hdr_cnt_q != 4'd0));
    // An accepted byte in the expiry cycle takes priority over the timeout.
    assign to_expire = to_run && !accept && (to_cnt_q == TO_W'(TIMEOUT - 1));

    // State register
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q         <= StHunt;
            hdr_cnt_q       <= '0;
            to_cnt_q        <= '0;
            pay_cnt_q       <= '0;
            frame_cmd_q     <= '0;
            frame_len_q     <= '0;
            rx_clear_q      <= 1'b0;
            payload_valid_q <= 1'b0;
            payload_data_q  <= '0;
            payload_idx_q   <= '0;
            err_valid_q     <= 1'b0;
            err_code_q      <= '0;
        end else begin
            state_q         <= state_d;
            hdr_cnt_q       <= hdr_cnt_d;
            to_cnt_q        <= to_cnt_d;
            pay_cnt_q       <= pay_cnt_d;
            frame_cmd_q     <= frame_cmd_d;
            frame_len_q     <= frame_len_d;
            rx_clear_q      <= rx_clear_d;
            payload_valid_q <= payload_valid_d;
            payload_data_q  <= payload_data_d;
            payload_idx_q   <= payload_idx_d;
            err_valid_q     <= err_valid_d;
            err_code_q      <= err_code_d;
        end
    end

    // Next-state logic
    always_comb begin
        state_d         = state_q;
        hdr_cnt_d       = hdr_cnt_q;
        to_cnt_d        = '0;
        pay_cnt_d       = pay_cnt_q;
        frame_cmd_d     = frame_cmd_q;
        frame_len_d     = frame_len_q;
        rx_clear_d      = accept;
        payload_valid_d = 1'b0;
        payload_data_d  = payload_data_q;
        payload_idx_d   = payload_idx_q;
        err_valid_d     = 1'b0;
        err_code_d      = err_code_q;

        if (to_run && !accept) begin
            to_cnt_d = to_cnt_q + TO_W'(1);
        end

        if (to_expire) begin
            state_d     = StHunt;
            hdr_cnt_d   = '0;
            to_cnt_d    = '0;
            err_valid_d = 1'b1;
            err_code_d  = ErrTimeout;
        end else begin
            unique case (state_q)
                StHunt: begin
                    if (accept) begin
                        if (rx_data == HDR_BYTE) begin
                            if (hdr_cnt_q == 4'(HDR_LEN - 1)) begin
                                hdr_cnt_d = '0;
                                state_d   = StCmd;
                            end else begin
                                hdr_cnt_d = hdr_cnt_q + 4'd1;
                            end
                        end else begin
                            hdr_cnt_d = '0;
                        end
                    end
                end
                StCmd: begin
                    if (accept) begin
                        if (cmd_ok) begin
                            frame_cmd_d = rx_data[CMD_W-1:0];
                            state_d     = StLen;
                        end else begin
                            err_valid_d = 1'b1;
                            err_code_d  = ErrCmd;
                            state_d     = StHunt;
                        end
                    end
                end
                StLen: begin
                    if (accept) begin
                        if (rx_data <= DATA_W'(MAX_LEN)) begin
                            frame_len_d = rx_data;
                            pay_cnt_d   = '0;
                            state_d     = (rx_data == '0) ? StDispatch : StPayload;
                        end else begin
                            err_valid_d = 1'b1;
                            err_code_d  = ErrLen;
                            state_d     = StHunt;
                        end
                    end
                end
                StPayload: begin
                    if (accept) begin
                        payload_valid_d = 1'b1;
                        payload_data_d  = rx_data;
                        payload_idx_d   = pay_cnt_q;
                        pay_cnt_d       = pay_cnt_q + DATA_W'(1);
                        if (pay_cnt_q == frame_len_q - DATA_W'(1)) begin
                            state_d = StDispatch;
                        end
                    end
                end
                StDispatch: state_d = StLocked;
                StLocked: begin
                    // Bytes received here are acknowledged and dropped.
                    if (done_hit) begin
                        state_d = StHunt;
                    end
                end
                default: state_d = StHunt;
            endcase
        end
    end

    // Outputs; cmd_active decodes straight from state so reset clears it at once.
    always_comb begin
        rx_clear      = rx_clear_q;
        payload_valid = payload_valid_q;
        payload_data  = payload_data_q;
        payload_idx   = payload_idx_q;
        frame_cmd     = frame_cmd_q;
        frame_len     = frame_len_q;
        err_valid     = err_valid_q;
        err_code      = err_code_q;
        idle          = (state_q == StHunt) && (hdr_cnt_q == 4'd0);
        cmd_start     = (state_q == StDispatch) ? cmd_sel : '0;
        cmd_active    = ((state_q == StDispatch) || (state_q == StLocked)) ? cmd_sel : '0;
    end

endmodule

// File: tb/tb_cmd_frame_parser.sv
// Testbench for cmd_frame_parser: directed scenarios plus randomized frames
// checked against a frame-level reference model.
module tb_cmd_frame_parser;

    localparam int TO = 10;

    logic       clk, reset, rx_valid;
    logic [7:0] rx_data;
    logic       rx_clear, payload_valid, idle, err_valid;
    logic [7:0] payload_data, payload_idx, frame_len;
    logic [2:0] frame_cmd;
    logic [3:0] cmd_start, cmd_active, cmd_done;
    logic [1:0] err_code;

    int n_checks = 0;
    int n_fail   = 0;
    int n_clear, bytes_sent;
    logic [15:0] obs_pay[$];
    logic [3:0]  obs_start[$];
    logic [1:0]  obs_err[$];

    cmd_frame_parser #(.TIMEOUT(TO)) dut (
        .clk(clk), .reset(reset), .rx_valid(rx_valid), .rx_data(rx_data),
        .rx_clear(rx_clear), .payload_valid(payload_valid), .payload_data(payload_data),
        .payload_idx(payload_idx), .frame_cmd(frame_cmd), .frame_len(frame_len),
        .cmd_start(cmd_start), .cmd_active(cmd_active), .cmd_done(cmd_done),
        .idle(idle), .err_valid(err_valid), .err_code(err_code)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Event monitor, sampled on the falling edge.
    always @(negedge clk) begin
        if (!reset) begin
            if (payload_valid) obs_pay.push_back({payload_idx, payload_data});
            if (cmd_start != 4'b0) obs_start.push_back(cmd_start);
            if (err_valid) obs_err.push_back(err_code);
            if (rx_clear) n_clear++;
        end
    end

    task automatic clear_mon();
        obs_pay.delete();
        obs_start.delete();
        obs_err.delete();
        n_clear    = 0;
        bytes_sent = 0;
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // Present one byte for one edge, then idle for gap cycles.
    task automatic send(input logic [7:0] b, input int gap);
        rx_data  = b;
        rx_valid = 1'b1;
        tick();
        rx_valid = 1'b0;
        bytes_sent++;
        repeat (gap) tick();
    endtask

    task automatic test_reset();
        reset = 1'b1; rx_valid = 1'b0; rx_data = 8'h00; cmd_done = 4'b0;
        repeat (3) tick();
        n_checks++;
        if ({rx_clear, payload_valid, err_valid, idle} !== 4'b0001) begin
            n_fail++;
            $display("FAIL reset_flags: got %b want 0001",
                     {rx_clear, payload_valid, err_valid, idle});
        end
        n_checks++;
        if ({cmd_start, cmd_active} !== 8'h00) begin
            n_fail++; $display("FAIL reset_cmd: got %h want 00", {cmd_start, cmd_active});
        end
        n_checks++;
        if ({frame_cmd, frame_len, err_code, payload_data, payload_idx} !== 29'd0) begin
            n_fail++; $display("FAIL reset_data: got %h want 0",
                               {frame_cmd, frame_len, err_code, payload_data, payload_idx});
        end
        reset = 1'b0;
        tick();
    endtask

    task automatic test_basic();
        clear_mon();
        send(8'hFE, 0); send(8'hFE, 0); send(8'h01, 0); send(8'h00, 0);
        n_checks++;
        if ({cmd_start, cmd_active} !== 8'b0001_0001) begin
            n_fail++; $display("FAIL basic_dispatch: got %b want 00010001", {cmd_start, cmd_active});
        end
        tick();
        n_checks++;
        if ({cmd_start, cmd_active} !== 8'b0000_0001) begin
            n_fail++; $display("FAIL basic_locked: got %b want 00000001", {cmd_start, cmd_active});
        end
        tick();
        n_checks++;
        if (n_clear !== 4 || obs_pay.size() !== 0 || obs_start.size() !== 1) begin
            n_fail++; $display("FAIL basic_counts: got clr=%0d pay=%0d start=%0d want 4 0 1",
                               n_clear, obs_pay.size(), obs_start.size());
        end
        cmd_done = 4'b0001; tick(); cmd_done = 4'b0;
        n_checks++;
        if (cmd_active !== 4'b0 || idle !== 1'b1) begin
            n_fail++; $display("FAIL basic_unlock: got act=%b idle=%b want 0000 1", cmd_active, idle);
        end
    endtask

    task automatic test_payload();
        logic [7:0]  seq[7] = '{8'hFE, 8'hFE, 8'h04, 8'h03, 8'hAA, 8'hBB, 8'hCC};
        logic [15:0] exp3[3] = '{16'h00AA, 16'h01BB, 16'h02CC};
        clear_mon();
        foreach (seq[i]) send(seq[i], 0);
        n_checks++;
        if ({payload_valid, payload_idx, payload_data, cmd_start} !== {1'b1, 8'd2, 8'hCC, 4'b1000}) begin
            n_fail++; $display("FAIL pay_last: got v=%b idx=%0d d=%h st=%b want 1 2 cc 1000",
                               payload_valid, payload_idx, payload_data, cmd_start);
        end
        tick();
        send(8'h55, 0);
        n_checks++;
        if (rx_clear !== 1'b1 || payload_valid !== 1'b0) begin
            n_fail++; $display("FAIL pay_locked_byte: got clr=%b pv=%b want 1 0", rx_clear, payload_valid);
        end
        tick();
        n_checks++;
        if (obs_pay.size() !== 3 || n_clear !== 8) begin
            n_fail++; $display("FAIL pay_counts: got pay=%0d clr=%0d want 3 8", obs_pay.size(), n_clear);
        end
        foreach (exp3[i]) begin
            if (i < obs_pay.size()) begin
                n_checks++;
                if (obs_pay[i] !== exp3[i]) begin
                    n_fail++; $display("FAIL pay_entry%0d: got %h want %h", i, obs_pay[i], exp3[i]);
                end
            end
        end
        cmd_done = 4'b0100; tick(); cmd_done = 4'b0;
        n_checks++;
        if (cmd_active !== 4'b1000) begin
            n_fail++; $display("FAIL pay_ignore_done: got %b want 1000", cmd_active);
        end
        cmd_done = 4'b1000; tick(); cmd_done = 4'b0;
        n_checks++;
        if (cmd_active !== 4'b0 || idle !== 1'b1) begin
            n_fail++; $display("FAIL pay_unlock: got act=%b idle=%b want 0000 1", cmd_active, idle);
        end
    endtask

    task automatic test_errors();
        logic [7:0] seq[$];
        logic [1:0] code;
        clear_mon();
        for (int e = 0; e < 3; e++) begin
            case (e)
                0:       begin seq = '{8'hFE, 8'hFE, 8'h05}; code = 2'd1; end
                1:       begin seq = '{8'hFE, 8'hFE, 8'h00}; code = 2'd1; end
                default: begin seq = '{8'hFE, 8'hFE, 8'h02, 8'h41}; code = 2'd2; end
            endcase
            foreach (seq[i]) send(seq[i], 0);
            n_checks++;
            if ({err_valid, err_code, idle} !== {1'b1, code, 1'b1}) begin
                n_fail++; $display("FAIL err%0d: got v=%b code=%0d idle=%b want 1 %0d 1",
                                   e, err_valid, err_code, idle, code);
            end
            tick();
            n_checks++;
            if (err_valid !== 1'b0) begin
                n_fail++; $display("FAIL err%0d_pulse: got %b want 0", e, err_valid);
            end
        end
        n_checks++;
        if (obs_start.size() !== 0 || frame_cmd !== 3'd2 || frame_len !== 8'd3) begin
            n_fail++; $display("FAIL err_side: got starts=%0d cmd=%0d len=%0d want 0 2 3",
                               obs_start.size(), frame_cmd, frame_len);
        end
    endtask

    task automatic test_resync();
        logic [7:0] seq[6] = '{8'hFE, 8'h12, 8'hFE, 8'hFE, 8'h03, 8'h00};
        foreach (seq[i]) send(seq[i], 0);
        n_checks++;
        if (cmd_start !== 4'b0100) begin
            n_fail++; $display("FAIL resync_start: got %b want 0100", cmd_start);
        end
        tick();
        cmd_done = 4'b0100; tick(); cmd_done = 4'b0;
    endtask

    task automatic test_timeout();
        int seen = 0;
        send(8'hFE, 0); send(8'hFE, 0); send(8'h02, 0);
        repeat (TO - 1) begin
            tick();
            if (err_valid) seen++;
        end
        n_checks++;
        if (seen !== 0) begin
            n_fail++; $display("FAIL to_early: got %0d errors want 0", seen);
        end
        tick();
        n_checks++;
        if ({err_valid, err_code, idle} !== 4'b1111) begin
            n_fail++; $display("FAIL to_fire: got v=%b code=%0d idle=%b want 1 3 1",
                               err_valid, err_code, idle);
        end
        tick();
        clear_mon();
        send(8'hFE, 0); send(8'hFE, 0); send(8'h02, 0);
        repeat (TO - 1) tick();
        send(8'h05, 0);
        n_checks++;
        if ({err_valid, rx_clear, frame_len} !== {1'b0, 1'b1, 8'd5}) begin
            n_fail++; $display("FAIL to_byte_wins: got v=%b clr=%b len=%0d want 0 1 5",
                               err_valid, rx_clear, frame_len);
        end
        for (int i = 0; i < 5; i++) send(8'(8'h30 + i), 0);
        n_checks++;
        if (cmd_start !== 4'b0010) begin
            n_fail++; $display("FAIL to_continue: got %b want 0010", cmd_start);
        end
        tick();
        cmd_done = 4'b0010; tick(); cmd_done = 4'b0;
        n_checks++;
        if (obs_err.size() !== 0 || obs_pay.size() !== 5) begin
            n_fail++; $display("FAIL to_events: got err=%0d pay=%0d want 0 5",
                               obs_err.size(), obs_pay.size());
        end
    endtask

    task automatic test_reset_mid();
        send(8'hFE, 0); send(8'hFE, 0); send(8'h03, 0); send(8'h05, 0);
        send(8'hAA, 0); send(8'hBB, 0);
        reset = 1'b1;
        #1;
        n_checks++;
        if ({rx_clear, payload_valid, err_valid, idle, cmd_start, cmd_active} !== 12'b0001_0000_0000 ||
            {frame_cmd, frame_len, err_code, payload_data, payload_idx} !== 29'd0) begin
            n_fail++; $display("FAIL rstmid_payload: got flags=%b data=%h want 000100000000 0",
                               {rx_clear, payload_valid, err_valid, idle, cmd_start, cmd_active},
                               {frame_cmd, frame_len, err_code, payload_data, payload_idx});
        end
        repeat (2) tick();
        reset = 1'b0;
        tick();
        send(8'hFE, 0); send(8'hFE, 0); send(8'h01, 0); send(8'h00, 0);
        tick();
        reset = 1'b1;
        #1;
        n_checks++;
        if (cmd_active !== 4'b0) begin
            n_fail++; $display("FAIL rstmid_async_active: got %b want 0000", cmd_active);
        end
        repeat (2) tick();
        reset = 1'b0;
        tick();
        clear_mon();
        send(8'hFE, 0); send(8'hFE, 0); send(8'h01, 0); send(8'h00, 0);
        n_checks++;
        if ({cmd_start, cmd_active} !== 8'b0001_0001) begin
            n_fail++; $display("FAIL rstmid_recover: got %b want 00010001", {cmd_start, cmd_active});
        end
        tick();
        cmd_done = 4'b0001; tick(); cmd_done = 4'b0;
    endtask

    // Random frames; expectations come from the frame description, not cycle timing.
    task automatic test_random();
        logic [15:0] exp_pay[$];
        logic [3:0]  exp_start[$];
        logic [1:0]  exp_err[$];
        logic [7:0]  fb[$];
        logic [3:0]  onehot, other;
        int kind, nj, h, n, p, cmd, len, w;
        clear_mon();
        for (int f = 0; f < 40; f++) begin
            fb.delete();
            kind = $urandom_range(0, 9);
            if ($urandom_range(0, 3) == 0) begin
                fb.push_back(8'hFE);
                fb.push_back(8'($urandom_range(0, 253)));
            end
            nj = $urandom_range(0, 2);
            for (int j = 0; j < nj; j++) fb.push_back(8'($urandom_range(0, 253)));
            h = fb.size();
            fb.push_back(8'hFE);
            fb.push_back(8'hFE);
            cmd = 0;
            if (kind == 0) begin
                cmd = ($urandom_range(0, 3) == 0) ? 0 : int'($urandom_range(5, 255));
                fb.push_back(8'(cmd));
                exp_err.push_back(2'd1);
            end else begin
                cmd = $urandom_range(1, 4);
                fb.push_back(8'(cmd));
                if (kind == 1) begin
                    fb.push_back(8'($urandom_range(65, 255)));
                    exp_err.push_back(2'd2);
                end else begin
                    len = ($urandom_range(0, 7) == 0) ? 64 : int'($urandom_range(0, 8));
                    fb.push_back(8'(len));
                    for (int j = 0; j < len; j++) fb.push_back(8'($urandom));
                    n = fb.size();
                    p = (kind == 2) ? int'($urandom_range(h + 1, n - 1)) : n;
                    for (int j = h + 4; j < p; j++) exp_pay.push_back({8'(j - h - 4), fb[j]});
                    if (kind == 2) exp_err.push_back(2'd3);
                    else exp_start.push_back(4'(1 << (cmd - 1)));
                    while (fb.size() > p) void'(fb.pop_back());
                end
            end
            foreach (fb[j]) send(fb[j], $urandom_range(0, 3));
            if (kind == 2) begin
                repeat (TO + 3) tick();
            end else if (kind >= 3) begin
                onehot = 4'(1 << (cmd - 1));
                w = 0;
                while (cmd_active == 4'b0 && w < 10) begin tick(); w++; end
                n_checks++;
                if (cmd_active !== onehot) begin
                    n_fail++; $display("FAIL rand_lock f%0d: got %b want %b", f, cmd_active, onehot);
                end
                tick();
                if ($urandom_range(0, 1) == 1) send(8'($urandom), 0);
                other = 4'($urandom) & ~onehot;
                if (other != 4'b0) begin
                    cmd_done = other; tick(); cmd_done = 4'b0;
                    n_checks++;
                    if (cmd_active !== onehot) begin
                        n_fail++; $display("FAIL rand_ignore f%0d: got %b want %b", f, cmd_active, onehot);
                    end
                end
                cmd_done = onehot | 4'($urandom); tick(); cmd_done = 4'b0;
                n_checks++;
                if (cmd_active !== 4'b0) begin
                    n_fail++; $display("FAIL rand_unlock f%0d: got %b want 0000", f, cmd_active);
                end
            end else begin
                tick();
            end
        end
        repeat (2) tick();
        n_checks++;
        if (obs_pay.size() !== exp_pay.size() || obs_start.size() !== exp_start.size() ||
            obs_err.size() !== exp_err.size()) begin
            n_fail++; $display("FAIL rand_sizes: got pay=%0d st=%0d err=%0d want %0d %0d %0d",
                               obs_pay.size(), obs_start.size(), obs_err.size(),
                               exp_pay.size(), exp_start.size(), exp_err.size());
        end
        foreach (exp_pay[i]) if (i < obs_pay.size()) begin
            n_checks++;
            if (obs_pay[i] !== exp_pay[i]) begin
                n_fail++; $display("FAIL rand_pay%0d: got %h want %h", i, obs_pay[i], exp_pay[i]);
            end
        end
        foreach (exp_start[i]) if (i < obs_start.size()) begin
            n_checks++;
            if (obs_start[i] !== exp_start[i]) begin
                n_fail++; $display("FAIL rand_start%0d: got %b want %b", i, obs_start[i], exp_start[i]);
            end
        end
        foreach (exp_err[i]) if (i < obs_err.size()) begin
            n_checks++;
            if (obs_err[i] !== exp_err[i]) begin
                n_fail++; $display("FAIL rand_err%0d: got %0d want %0d", i, obs_err[i], exp_err[i]);
            end
        end
        n_checks++;
        if (n_clear !== bytes_sent) begin
            n_fail++; $display("FAIL rand_clear: got %0d want %0d", n_clear, bytes_sent);
        end
    endtask

    initial begin
        test_reset();
        test_basic();
        test_payload();
        test_errors();
        test_resync();
        test_timeout();
        test_reset_mid();
        test_random();
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

    initial begin
        #5_000_000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1);
    end

endmodule
